// File: rtl/traffic_grant_scheduler.sv
// -----------------------------------------------------------------------------
// traffic_grant_scheduler
//   Arbitrates four direction requests for the intersection light sequencer.
//   The sequencer serves one direction at a time. This block latches the
//   requests, picks the next direction round-robin, and ages waiting requests
//   so that no direction starves. An emergency pre-emption request takes
//   priority at the next decision. Each grant is handed over with a
//   valid/ready handshake.
//
// Ports
//   clk          : clock
//   reset        : asynchronous, active-high reset
//   req_in[3:0]  : per-direction request; any high cycle latches pending[i]
//   emerg_in     : emergency request strobe
//   emerg_dir    : emergency direction, sampled with emerg_in
//   grant_ready  : sequencer accepts the offered grant
//   phase_done   : 1-cycle pulse, sequencer finished serving grant_dir
//   grant_valid  : grant offered
//   grant_dir    : granted direction, stable while grant_valid=1
//   grant_emerg  : offered grant is an emergency grant
//   pending[3:0] : latched outstanding requests
//   starve[3:0]  : wait count of direction i has reached MAX_WAIT
//   busy         : scheduler is offering or serving a grant
// -----------------------------------------------------------------------------
module traffic_grant_scheduler #(
    parameter logic [23:0] TICK_DIV = 24'd1_000_000,
    parameter logic [7:0]  MAX_WAIT = 8'd30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req_in,
    input  logic       emerg_in,
    input  logic [1:0] emerg_dir,
    input  logic       grant_ready,
    input  logic       phase_done,
    output logic       grant_valid,
    output logic [1:0] grant_dir,
    output logic       grant_emerg,
    output logic [3:0] pending,
    output logic [3:0] starve,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OFFER = 2'd1,
        S_SERVE = 2'd2
    } state_t;

    state_t      state_q;
    logic [23:0] tick_cnt_q, tick_cnt_d;
    logic        tick;
    logic [3:0]  pending_q, pending_d;
    logic [3:0]  clr;
    logic [7:0]  wait_q [4];
    logic [7:0]  wait_d [4];
    logic        emerg_pend_q, emerg_pend_d;
    logic [1:0]  emerg_dir_q, emerg_dir_d;
    logic [1:0]  last_dir_q;
    logic        grant_valid_q;
    logic [1:0]  grant_dir_q;
    logic        grant_emerg_q;
    logic        busy_q;
    logic        hs;
    logic [2:0]  starve_pick;
    logic [2:0]  pend_pick;

    // Round-robin search starting just after 'last'. Returns {found, index}.
    // The loop runs from the lowest-priority slot to the highest so the
    // last match written is the winner.
    function automatic logic [2:0] rr_pick(input logic [3:0] vec,
                                           input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (vec[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

    assign tick       = (tick_cnt_q == TICK_DIV - 24'd1);
    assign tick_cnt_d = tick ? 24'd0 : tick_cnt_q + 24'd1;

    // In OFFER grant_valid is always high, so the handshake is OFFER & ready.
    assign hs  = (state_q == S_OFFER) && grant_ready;
    assign clr = hs ? (4'b0001 << grant_dir_q) : 4'b0000;

    // A same-cycle request wins over the handshake clear.
    assign pending_d = (pending_q & ~clr) | req_in;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            starve[i] = (wait_q[i] >= MAX_WAIT);
            wait_d[i] = wait_q[i];
            if (clr[i]) begin
                wait_d[i] = 8'd0;
            end else if (tick && pending_q[i] && (wait_q[i] < MAX_WAIT) &&
                         !((state_q != S_IDLE) && (grant_dir_q == 2'(i)))) begin
                // The direction currently offered or served does not age.
                wait_d[i] = wait_q[i] + 8'd1;
            end
        end
    end

    always_comb begin
        emerg_pend_d = emerg_pend_q;
        emerg_dir_d  = emerg_dir_q;
        if (emerg_in) begin
            // A new strobe always wins, even in the cycle its grant is taken.
            emerg_pend_d = 1'b1;
            emerg_dir_d  = emerg_dir;
        end else if (hs && grant_emerg_q) begin
            emerg_pend_d = 1'b0;
        end
    end

    assign starve_pick = rr_pick(starve, last_dir_q);
    assign pend_pick   = rr_pick(pending_q, last_dir_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            tick_cnt_q    <= 24'd0;
            pending_q     <= 4'b0000;
            for (int i = 0; i < 4; i++) wait_q[i] <= 8'd0;
            emerg_pend_q  <= 1'b0;
            emerg_dir_q   <= 2'd0;
            last_dir_q    <= 2'd3;
            grant_valid_q <= 1'b0;
            grant_dir_q   <= 2'd0;
            grant_emerg_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            pending_q    <= pending_d;
            for (int i = 0; i < 4; i++) wait_q[i] <= wait_d[i];
            emerg_pend_q <= emerg_pend_d;
            emerg_dir_q  <= emerg_dir_d;

            case (state_q)
                S_IDLE: begin
                    // Decision is taken from registered state only, so a
                    // request reaches grant_valid two edges after it is seen.
                    if (emerg_pend_q) begin
                        grant_dir_q   <= emerg_dir_q;
                        grant_emerg_q <= 1'b1;
                        grant_valid_q <= 1'b1;
                        busy_q        <= 1'b1;
                        state_q       <= S_OFFER;
                    end else if (starve_pick[2]) begin
                        grant_dir_q   <= starve_pick[1:0];
                        grant_emerg_q <= 1'b0;
                        grant_valid_q <= 1'b1;
                        busy_q        <= 1'b1;
                        state_q       <= S_OFFER;
                    end else if (pend_pick[2]) begin
                        grant_dir_q   <= pend_pick[1:0];
                        grant_emerg_q <= 1'b0;
                        grant_valid_q <= 1'b1;
                        busy_q        <= 1'b1;
                        state_q       <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    // The offer is frozen until taken; emergencies only latch.
                    if (grant_ready) begin
                        grant_valid_q <= 1'b0;
                        state_q       <= S_SERVE;
                        if (!grant_emerg_q) last_dir_q <= grant_dir_q;
                    end
                end
                S_SERVE: begin
                    if (phase_done) begin
                        grant_emerg_q <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= S_IDLE;
                    end
                end
                default: begin
                    grant_valid_q <= 1'b0;
                    busy_q        <= 1'b0;
                    state_q       <= S_IDLE;
                end
            endcase
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_dir   = grant_dir_q;
    assign grant_emerg = grant_emerg_q;
    assign pending     = pending_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_traffic_grant_scheduler.sv
module tb_traffic_grant_scheduler;

    localparam int TD = 4;
    localparam int MW = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_in;
    logic       emerg_in;
    logic [1:0] emerg_dir;
    logic       grant_ready;
    logic       phase_done;
    logic       grant_valid;
    logic [1:0] grant_dir;
    logic       grant_emerg;
    logic [3:0] pending;
    logic [3:0] starve;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    traffic_grant_scheduler #(
        .TICK_DIV(24'(TD)),
        .MAX_WAIT(8'(MW))
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_in     (req_in),
        .emerg_in   (emerg_in),
        .emerg_dir  (emerg_dir),
        .grant_ready(grant_ready),
        .phase_done (phase_done),
        .grant_valid(grant_valid),
        .grant_dir  (grant_dir),
        .grant_emerg(grant_emerg),
        .pending    (pending),
        .starve     (starve),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 = waiting for work, 1 = grant offered, 2 = being served
    int       m_mode;
    bit [3:0] m_pend;
    int       m_wait [4];
    bit       m_emerg;
    int       m_edir;
    int       m_last;
    int       m_gdir;
    bit       m_gem;
    int       m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pend  = 4'b0000;
        for (int i = 0; i < 4; i++) m_wait[i] = 0;
        m_emerg = 1'b0;
        m_edir  = 0;
        m_last  = 3;
        m_gdir  = 0;
        m_gem   = 1'b0;
        m_cnt   = 0;
    endtask

    function automatic int rr_first(input bit [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (v[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step();
        bit       tick;
        bit       hs;
        bit [3:0] np;
        bit [3:0] sv;
        int       nw [4];
        int       d;
        tick = (m_cnt == TD - 1);
        hs   = (m_mode == 1) && grant_ready;
        for (int i = 0; i < 4; i++) begin
            bit taken;
            taken = hs && (m_gdir == i);
            np[i] = (m_pend[i] && !taken) || req_in[i];
            nw[i] = m_wait[i];
            if (taken) nw[i] = 0;
            else if (tick && m_pend[i] && !(m_mode != 0 && m_gdir == i) && nw[i] < MW)
                nw[i] = nw[i] + 1;
            sv[i] = (m_wait[i] >= MW);
        end
        case (m_mode)
            0: begin
                if (m_emerg) begin
                    m_gdir = m_edir; m_gem = 1'b1; m_mode = 1;
                end else if (rr_first(sv, m_last) >= 0) begin
                    m_gdir = rr_first(sv, m_last); m_gem = 1'b0; m_mode = 1;
                end else begin
                    d = rr_first(m_pend, m_last);
                    if (d >= 0) begin
                        m_gdir = d; m_gem = 1'b0; m_mode = 1;
                    end
                end
            end
            1: begin
                if (hs) begin
                    if (m_gem) begin
                        if (!emerg_in) m_emerg = 1'b0;
                    end else begin
                        m_last = m_gdir;
                    end
                    m_mode = 2;
                end
            end
            default: begin
                if (phase_done) begin
                    m_mode = 0; m_gem = 1'b0;
                end
            end
        endcase
        if (emerg_in) begin
            m_emerg = 1'b1;
            m_edir  = int'(emerg_dir);
        end
        m_pend = np;
        for (int i = 0; i < 4; i++) m_wait[i] = nw[i];
        m_cnt = tick ? 0 : m_cnt + 1;
    endtask

    task automatic compare_all();
        logic [12:0] got, exp;
        logic [3:0]  es;
        for (int i = 0; i < 4; i++) es[i] = (m_wait[i] >= MW);
        got = {grant_valid, grant_dir, grant_emerg, pending, starve, busy};
        exp = {(m_mode == 1), 2'(m_gdir), m_gem, m_pend, es, (m_mode != 0)};
        chk("outs", 32'(got), 32'(exp));
    endtask

    // One clock: model follows the active edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_grant(input string tag);
        int n;
        n = 0;
        while (!grant_valid && n < 40) begin
            cycle();
            n++;
        end
        chk({tag, "_timeout"}, 32'(grant_valid), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        cycle();
        reset = 1'b0;
    endtask

    task automatic finish_grant(input int hold);
        // assumes grant_ready=1 and an offer present: handshake, hold, phase_done
        cycle();
        for (int i = 0; i < hold; i++) cycle();
        phase_done = 1'b1;
        cycle();
        phase_done = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        req_in      = 4'b0000;
        emerg_in    = 1'b0;
        emerg_dir   = 2'd0;
        grant_ready = 1'b1;
        phase_done  = 1'b0;
        model_reset();
        #12;
        chk("rst_state", 32'({grant_valid, grant_dir, grant_emerg, pending, starve, busy}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single request: two-edge latency, cleared on handshake, busy until phase_done
        req_in = 4'b0100;
        cycle();
        req_in = 4'b0000;
        chk("t1_latency", 32'(grant_valid), 32'd0);
        cycle();
        chk("t1_valid", 32'(grant_valid), 32'd1);
        chk("t1_dir", 32'(grant_dir), 32'd2);
        cycle();
        chk("t1_pend_clr", 32'(pending), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        cycle();
        phase_done = 1'b1;
        cycle();
        phase_done = 1'b0;
        chk("t1_idle", 32'(busy), 32'd0);

        // All four at once: served 0,1,2,3, then a new request for 0
        do_reset();
        req_in = 4'b1111;
        cycle();
        req_in = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            wait_grant("t2_grant");
            chk($sformatf("t2_order%0d", k), 32'(grant_dir), 32'(k));
            finish_grant(4);
        end
        req_in = 4'b0001;
        cycle();
        req_in = 4'b0000;
        wait_grant("t2_again");
        chk("t2_again_dir", 32'(grant_dir), 32'd0);
        finish_grant(1);

        // Emergency during a stalled offer: offer stays, emergency served next
        do_reset();
        grant_ready = 1'b0;
        req_in = 4'b0010;
        cycle();
        req_in = 4'b0000;
        wait_grant("t3_grant");
        emerg_in = 1'b1;
        emerg_dir = 2'd3;
        cycle();
        emerg_in = 1'b0;
        cycle();
        chk("t3_frozen_dir", 32'(grant_dir), 32'd1);
        chk("t3_frozen_em", 32'(grant_emerg), 32'd0);
        grant_ready = 1'b1;
        finish_grant(2);
        wait_grant("t3_emerg");
        chk("t3_emerg_dir", 32'(grant_dir), 32'd3);
        chk("t3_emerg_flag", 32'(grant_emerg), 32'd1);
        finish_grant(1);

        // Aging: dir3 starves while dir1 is served and overtakes a fresh dir2
        do_reset();
        req_in = 4'b0001;
        cycle();
        req_in = 4'b0000;
        wait_grant("t4_g0");
        finish_grant(1);
        req_in = 4'b0010;
        cycle();
        req_in = 4'b0000;
        wait_grant("t4_g1");
        cycle();
        req_in = 4'b1000;
        cycle();
        req_in = 4'b0000;
        for (int i = 0; i < 14; i++) cycle();
        chk("t4_starve3", 32'(starve[3]), 32'd1);
        req_in = 4'b0100;
        cycle();
        req_in = 4'b0000;
        phase_done = 1'b1;
        cycle();
        phase_done = 1'b0;
        wait_grant("t4_g3");
        chk("t4_starved_first", 32'(grant_dir), 32'd3);
        finish_grant(1);
        wait_grant("t4_g2");
        chk("t4_then_dir2", 32'(grant_dir), 32'd2);
        finish_grant(1);

        // Request in the handshake cycle survives the clear
        do_reset();
        req_in = 4'b0100;
        cycle();
        req_in = 4'b0000;
        wait_grant("t5_grant");
        req_in = 4'b0100;
        cycle();
        req_in = 4'b0000;
        chk("t5_pend_kept", 32'(pending[2]), 32'd1);
        cycle();
        phase_done = 1'b1;
        cycle();
        phase_done = 1'b0;
        wait_grant("t5_regrant");
        chk("t5_regrant_dir", 32'(grant_dir), 32'd2);

        // Asynchronous reset while serving
        cycle();
        cycle();
        chk("t6_in_serve", 32'(busy), 32'd1);
        req_in = 4'b1010;
        cycle();
        req_in = 4'b0000;
        reset = 1'b1;
        #1;
        chk("t6_async", 32'({grant_valid, grant_emerg, pending, busy}), 32'd0);
        model_reset();
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        chk("t6_no_grant", 32'(grant_valid), 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            req_in      = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            emerg_in    = ($urandom_range(0, 40) == 0);
            emerg_dir   = 2'($urandom);
            grant_ready = ($urandom_range(0, 9) < 7);
            phase_done  = ($urandom_range(0, 5) == 0);
            reset       = ($urandom_range(0, 999) == 0);
            if (reset) model_reset();
            cycle();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
